// File: rtl/red_blob_locator.sv
// red_blob_locator: accumulates per-frame statistics of the pixels that pass
// the colour filter (non-zero RGB). At frame end it takes a snapshot and runs a
// 31-step restoring divide to report the blob centroid, bounding box and hit
// count as one result record per frame.
//
// Output handshake: oValid is a single-cycle strobe with no ready/back-pressure.
// The result outputs change only on the cycle oValid is high and hold their
// values until the next strobe, so the consumer may capture on the strobe or at
// any time afterwards. oOverrun is a single-cycle strobe of the same kind.
module red_blob_locator #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int MIN_PIXELS = 16
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic [11:0] iRed,
  input  logic [11:0] iGreen,
  input  logic [11:0] iBlue,
  input  logic        iDVAL,
  output logic        oValid,
  output logic        oFound,
  output logic [10:0] oCentX,
  output logic [10:0] oCentY,
  output logic [19:0] oPixCount,
  output logic [10:0] oMinX,
  output logic [10:0] oMaxX,
  output logic [10:0] oMinY,
  output logic [10:0] oMaxY,
  output logic        oOverrun,
  output logic [1:0]  dbg_state
);

  localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);
  localparam logic [19:0] MIN_P  = 20'(MIN_PIXELS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Running accumulators for the frame currently streaming in.
  logic [19:0] acc_cnt;
  logic [30:0] acc_sx, acc_sy;
  logic [10:0] acc_minx, acc_maxx, acc_miny, acc_maxy;

  // Accumulator values including the current pixel's contribution.
  logic [19:0] cnt_n;
  logic [30:0] sx_n, sy_n;
  logic [10:0] minx_n, maxx_n, miny_n, maxy_n;

  // Snapshot and divider working registers.
  logic [19:0] div_cnt;
  logic [30:0] dvd_x, dvd_y;
  logic [19:0] rem_x, rem_y;
  logic [10:0] q_x, q_y;
  logic [4:0]  iter;
  logic [10:0] snap_minx, snap_maxx, snap_miny, snap_maxy;

  logic hit, frame_end, accept;
  logic [20:0] trial_x, trial_y;
  logic [19:0] diff_x, diff_y;
  logic ge_x, ge_y;

  // Pixel qualification: out-of-range or invalid samples are ignored entirely.
  always_comb begin
    hit       = iDVAL && (iX_Cont <= X_LAST) && (iY_Cont <= Y_LAST)
                && (|{iRed, iGreen, iBlue});
    frame_end = iDVAL && (iX_Cont == X_LAST) && (iY_Cont == Y_LAST);
    accept    = frame_end && (state_q == IDLE);
  end

  // Next accumulator values; the first hit of a frame loads min/max directly.
  always_comb begin
    cnt_n  = acc_cnt;
    sx_n   = acc_sx;
    sy_n   = acc_sy;
    minx_n = acc_minx;
    maxx_n = acc_maxx;
    miny_n = acc_miny;
    maxy_n = acc_maxy;
    if (hit) begin
      cnt_n = acc_cnt + 20'd1;
      sx_n  = acc_sx + 31'(iX_Cont);
      sy_n  = acc_sy + 31'(iY_Cont);
      if (acc_cnt == 20'd0) begin
        minx_n = iX_Cont;
        maxx_n = iX_Cont;
        miny_n = iY_Cont;
        maxy_n = iY_Cont;
      end else begin
        if (iX_Cont < acc_minx) minx_n = iX_Cont;
        if (iX_Cont > acc_maxx) maxx_n = iX_Cont;
        if (iY_Cont < acc_miny) miny_n = iY_Cont;
        if (iY_Cont > acc_maxy) maxy_n = iY_Cont;
      end
    end
  end

  // Accumulators clear at every frame end so the next frame overlaps the divide.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      acc_cnt  <= '0;
      acc_sx   <= '0;
      acc_sy   <= '0;
      acc_minx <= '0;
      acc_maxx <= '0;
      acc_miny <= '0;
      acc_maxy <= '0;
    end else if (frame_end) begin
      acc_cnt  <= '0;
      acc_sx   <= '0;
      acc_sy   <= '0;
      acc_minx <= '0;
      acc_maxx <= '0;
      acc_miny <= '0;
      acc_maxy <= '0;
    end else begin
      acc_cnt  <= cnt_n;
      acc_sx   <= sx_n;
      acc_sy   <= sy_n;
      acc_minx <= minx_n;
      acc_maxx <= maxx_n;
      acc_miny <= miny_n;
      acc_maxy <= maxy_n;
    end
  end

  // One restoring-divide step for X and Y, sharing the count as divisor.
  // diff is only used when trial >= divisor, so its 20-bit result is exact.
  always_comb begin
    trial_x = {rem_x, dvd_x[30]};
    trial_y = {rem_y, dvd_y[30]};
    ge_x    = (trial_x >= {1'b0, div_cnt});
    ge_y    = (trial_y >= {1'b0, div_cnt});
    diff_x  = trial_x[19:0] - div_cnt;
    diff_y  = trial_y[19:0] - div_cnt;
  end

  // Snapshot on an accepted frame end, then shift one quotient bit per cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      div_cnt   <= '0;
      dvd_x     <= '0;
      dvd_y     <= '0;
      rem_x     <= '0;
      rem_y     <= '0;
      q_x       <= '0;
      q_y       <= '0;
      iter      <= '0;
      snap_minx <= '0;
      snap_maxx <= '0;
      snap_miny <= '0;
      snap_maxy <= '0;
    end else if (accept) begin
      div_cnt   <= cnt_n;
      dvd_x     <= sx_n;
      dvd_y     <= sy_n;
      rem_x     <= '0;
      rem_y     <= '0;
      q_x       <= '0;
      q_y       <= '0;
      iter      <= '0;
      snap_minx <= minx_n;
      snap_maxx <= maxx_n;
      snap_miny <= miny_n;
      snap_maxy <= maxy_n;
    end else if (state_q == DIV) begin
      dvd_x <= {dvd_x[29:0], 1'b0};
      dvd_y <= {dvd_y[29:0], 1'b0};
      rem_x <= ge_x ? diff_x : trial_x[19:0];
      rem_y <= ge_y ? diff_y : trial_y[19:0];
      q_x   <= {q_x[9:0], ge_x};
      q_y   <= {q_y[9:0], ge_y};
      iter  <= iter + 5'd1;
    end
  end

  // Divider FSM state register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Divider FSM next state: 31 DIV cycles, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_end) state_d = DIV;
      DIV:     if (iter == 5'd30) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers and strobes; an empty frame reports all zeros.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oValid    <= 1'b0;
      oOverrun  <= 1'b0;
      oFound    <= 1'b0;
      oCentX    <= '0;
      oCentY    <= '0;
      oPixCount <= '0;
      oMinX     <= '0;
      oMaxX     <= '0;
      oMinY     <= '0;
      oMaxY     <= '0;
    end else begin
      oValid   <= (state_q == DONE);
      oOverrun <= frame_end && (state_q != IDLE);
      if (state_q == DONE) begin
        if (div_cnt == 20'd0) begin
          oFound    <= 1'b0;
          oCentX    <= '0;
          oCentY    <= '0;
          oPixCount <= '0;
          oMinX     <= '0;
          oMaxX     <= '0;
          oMinY     <= '0;
          oMaxY     <= '0;
        end else begin
          oFound    <= (div_cnt >= MIN_P);
          oCentX    <= q_x;
          oCentY    <= q_y;
          oPixCount <= div_cnt;
          oMinX     <= snap_minx;
          oMaxX     <= snap_maxx;
          oMinY     <= snap_miny;
          oMaxY     <= snap_maxy;
        end
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_red_blob_locator.sv
// Bench for red_blob_locator on a 4x3 frame. Two instances share the stimulus
// and differ only in MIN_PIXELS (1 and 4) so the found threshold is exercised.
module tb_red_blob_locator;

  localparam int W = 4;
  localparam int H = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] x, y;
  logic [11:0] r, g, b;
  logic        dval;

  logic        a_valid, a_found, a_overrun;
  logic [10:0] a_cx, a_cy, a_minx, a_maxx, a_miny, a_maxy;
  logic [19:0] a_pixcount;
  logic [1:0]  a_state;
  logic        b_valid, b_found, b_overrun;
  logic [10:0] b_cx, b_cy, b_minx, b_maxx, b_miny, b_maxy;
  logic [19:0] b_pixcount;
  logic [1:0]  b_state;

  red_blob_locator #(.WIDTH(W), .HEIGHT(H), .MIN_PIXELS(1)) dut_a (
    .iCLK(clk), .iRST_N(rst_n), .iX_Cont(x), .iY_Cont(y),
    .iRed(r), .iGreen(g), .iBlue(b), .iDVAL(dval),
    .oValid(a_valid), .oFound(a_found), .oCentX(a_cx), .oCentY(a_cy),
    .oPixCount(a_pixcount), .oMinX(a_minx), .oMaxX(a_maxx),
    .oMinY(a_miny), .oMaxY(a_maxy), .oOverrun(a_overrun), .dbg_state(a_state)
  );

  red_blob_locator #(.WIDTH(W), .HEIGHT(H), .MIN_PIXELS(4)) dut_b (
    .iCLK(clk), .iRST_N(rst_n), .iX_Cont(x), .iY_Cont(y),
    .iRed(r), .iGreen(g), .iBlue(b), .iDVAL(dval),
    .oValid(b_valid), .oFound(b_found), .oCentX(b_cx), .oCentY(b_cy),
    .oPixCount(b_pixcount), .oMinX(b_minx), .oMaxX(b_maxx),
    .oMinY(b_miny), .oMaxY(b_maxy), .oOverrun(b_overrun), .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  // Record layout: {count[19:0], cx, cy, minx, maxx, miny, maxy}
  logic [85:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int overrun_cnt = 0;

  // Bench-side model of the frame currently being driven.
  int m_cnt = 0, m_sx = 0, m_sy = 0;
  int m_minx = 0, m_maxx = 0, m_miny = 0, m_maxy = 0;
  logic [85:0] last_rec;

  function automatic logic [85:0] make_rec();
    if (m_cnt == 0) return '0;
    return {20'(m_cnt), 11'(m_sx / m_cnt), 11'(m_sy / m_cnt),
            11'(m_minx), 11'(m_maxx), 11'(m_miny), 11'(m_maxy)};
  endfunction

  always @(negedge clk) begin
    logic [85:0] e;
    if (rst_n) begin
      if (a_overrun) overrun_cnt++;
      if (a_valid) begin
        valid_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid: got oValid=1 with no result expected");
        end else begin
          e = exp_q.pop_front();
          if ({a_pixcount, a_cx, a_cy, a_minx, a_maxx, a_miny, a_maxy} !== e) begin
            n_bad++;
            $display("FAIL record_a: got cnt=%0d cent=(%0d,%0d) x=%0d..%0d y=%0d..%0d, want cnt=%0d cent=(%0d,%0d) x=%0d..%0d y=%0d..%0d",
              a_pixcount, a_cx, a_cy, a_minx, a_maxx, a_miny, a_maxy,
              e[85:66], e[65:55], e[54:44], e[43:33], e[32:22], e[21:11], e[10:0]);
          end
          n_cmp++;
          if ({b_valid, b_pixcount, b_cx, b_cy, b_minx, b_maxx, b_miny, b_maxy} !== {1'b1, e}) begin
            n_bad++;
            $display("FAIL record_b: got valid=%0b cnt=%0d cent=(%0d,%0d), want valid=1 cnt=%0d cent=(%0d,%0d)",
              b_valid, b_pixcount, b_cx, b_cy, e[85:66], e[65:55], e[54:44]);
          end
          n_cmp++;
          if (a_found !== (e[85:66] >= 20'd1)) begin
            n_bad++;
            $display("FAIL found_a: got %0b want %0b (cnt=%0d)", a_found, (e[85:66] >= 20'd1), e[85:66]);
          end
          n_cmp++;
          if (b_found !== (e[85:66] >= 20'd4)) begin
            n_bad++;
            $display("FAIL found_b: got %0b want %0b (cnt=%0d)", b_found, (e[85:66] >= 20'd4), e[85:66]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_px(input int px, input int py, input logic [11:0] pr,
                          input logic [11:0] pg, input logic [11:0] pb, input logic pdv);
    x = 11'(px); y = 11'(py); r = pr; g = pg; b = pb; dval = pdv;
    if (pdv && px < W && py < H && (pr | pg | pb) != 12'd0) begin
      if (m_cnt == 0) begin
        m_minx = px; m_maxx = px; m_miny = py; m_maxy = py;
      end else begin
        if (px < m_minx) m_minx = px;
        if (px > m_maxx) m_maxx = px;
        if (py < m_miny) m_miny = py;
        if (py > m_maxy) m_maxy = py;
      end
      m_cnt++; m_sx += px; m_sy += py;
    end
    if (pdv && px == W - 1 && py == H - 1) begin
      last_rec = make_rec();
      m_cnt = 0; m_sx = 0; m_sy = 0;
      m_minx = 0; m_maxx = 0; m_miny = 0; m_maxy = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    dval = 1'b0; r = '0; g = '0; b = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Full raster frame; bit (y*W + x) of mask selects a non-zero pixel.
  task automatic drive_frame(input logic [11:0] mask);
    logic [11:0] v;
    int c;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        if (mask[yy * W + xx]) begin
          v = 12'($urandom_range(1, 4095));
          c = $urandom_range(0, 2);
          drive_px(xx, yy, (c == 0) ? v : 12'd0, (c == 1) ? v : 12'd0, (c == 2) ? v : 12'd0, 1'b1);
        end else begin
          drive_px(xx, yy, 12'd0, 12'd0, 12'd0, 1'b1);
        end
      end
    end
  endtask

  // Cycles after the last driven edge until oValid is seen; -1 on timeout.
  task automatic wait_valid(input int budget, output int lat);
    bit seen;
    seen = 1'b0;
    lat = -1;
    dval = 1'b0; r = '0; g = '0; b = '0;
    for (int k = 1; k <= budget; k++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (a_valid) begin
          seen = 1'b1;
          lat = k;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    x = '0; y = '0; r = '0; g = '0; b = '0; dval = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_valid, a_found, a_overrun, a_pixcount, a_cx, a_cy, a_minx, a_maxx, a_miny, a_maxy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs_a: got cnt=%0d cent=(%0d,%0d) valid=%0b, want all 0", a_pixcount, a_cx, a_cy, a_valid);
    end
    n_cmp++;
    if ({b_valid, b_found, b_overrun, b_pixcount, b_cx, b_cy, b_minx, b_maxx, b_miny, b_maxy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs_b: got cnt=%0d valid=%0b, want all 0", b_pixcount, b_valid);
    end
    n_cmp++;
    if (a_state !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want 0", a_state);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single_hit();
    int lat;
    drive_frame(12'h800);
    exp_q.push_back(last_rec);
    wait_valid(40, lat);
    n_cmp++;
    if (lat !== 32) begin
      n_bad++;
      $display("FAIL single_latency: got %0d want 32", lat);
    end
    n_cmp++;
    if ({a_pixcount, a_cx, a_cy, a_minx, a_maxx, a_miny, a_maxy, a_found}
        !== {20'd1, 11'd3, 11'd2, 11'd3, 11'd3, 11'd2, 11'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL single_values: got cnt=%0d cent=(%0d,%0d) found=%0b, want cnt=1 cent=(3,2) found=1",
        a_pixcount, a_cx, a_cy, a_found);
    end
    idle(1);
    n_cmp++;
    if (a_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pulse_width: got oValid=%0b a cycle later, want 0", a_valid);
    end
    idle(3);
  endtask

  task automatic test_empty_frame();
    int lat;
    drive_frame(12'h000);
    exp_q.push_back(last_rec);
    wait_valid(40, lat);
    n_cmp++;
    if (lat !== 32) begin
      n_bad++;
      $display("FAIL empty_latency: got %0d want 32", lat);
    end
    n_cmp++;
    if ({a_found, a_pixcount, a_cx, a_cy, a_minx, a_maxx, a_miny, a_maxy} !== '0) begin
      n_bad++;
      $display("FAIL empty_values: got cnt=%0d cent=(%0d,%0d) x=%0d..%0d found=%0b, want all 0",
        a_pixcount, a_cx, a_cy, a_minx, a_maxx, a_found);
    end
    idle(3);
  endtask

  task automatic test_three_hits();
    int lat;
    drive_frame(12'h068);  // (3,0), (1,1), (2,1)
    exp_q.push_back(last_rec);
    wait_valid(40, lat);
    n_cmp++;
    if ({a_pixcount, a_cx, a_cy, a_minx, a_maxx, a_miny, a_maxy}
        !== {20'd3, 11'd2, 11'd0, 11'd1, 11'd3, 11'd0, 11'd1}) begin
      n_bad++;
      $display("FAIL three_values: got cnt=%0d cent=(%0d,%0d) x=%0d..%0d y=%0d..%0d, want cnt=3 cent=(2,0) x=1..3 y=0..1",
        a_pixcount, a_cx, a_cy, a_minx, a_maxx, a_miny, a_maxy);
    end
    n_cmp++;
    if ({a_found, b_found} !== 2'b10) begin
      n_bad++;
      $display("FAIL three_found: got a=%0b b=%0b, want a=1 b=0", a_found, b_found);
    end
    idle(6);
    n_cmp++;
    if ({a_pixcount, a_cx, a_minx, a_maxx} !== {20'd3, 11'd2, 11'd1, 11'd3}) begin
      n_bad++;
      $display("FAIL three_hold: got cnt=%0d cx=%0d x=%0d..%0d, want cnt=3 cx=2 x=1..3",
        a_pixcount, a_cx, a_minx, a_maxx);
    end
  endtask

  task automatic test_ignored_samples();
    int lat;
    int v0;
    v0 = valid_cnt;
    drive_px(3, 2, 12'hFFF, 12'h0, 12'h0, 1'b0);  // would be frame end, but not valid
    drive_px(5, 1, 12'h0, 12'h123, 12'h0, 1'b1);  // X out of range
    drive_px(1, 3, 12'h0, 12'h0, 12'h456, 1'b1);  // Y out of range
    drive_px(0, 0, 12'h789, 12'h0, 12'h0, 1'b0);  // invalid
    idle(40);
    n_cmp++;
    if (valid_cnt !== v0) begin
      n_bad++;
      $display("FAIL ignored_no_frame_end: got %0d results want 0", valid_cnt - v0);
    end
    drive_px(2, 2, 12'h001, 12'h0, 12'h0, 1'b1);
    drive_px(3, 2, 12'h0, 12'h0, 12'h0, 1'b1);    // real frame end, no hit
    exp_q.push_back(last_rec);
    wait_valid(40, lat);
    n_cmp++;
    if ({lat, a_pixcount, a_cx, a_cy} !== {32'sd32, 20'd1, 11'd2, 11'd2}) begin
      n_bad++;
      $display("FAIL ignored_values: got lat=%0d cnt=%0d cent=(%0d,%0d), want lat=32 cnt=1 cent=(2,2)",
        lat, a_pixcount, a_cx, a_cy);
    end
    idle(3);
  endtask

  task automatic test_random_frames();
    int lat;
    for (int i = 0; i < 5; i++) begin
      drive_frame(12'($urandom_range(0, 4095)));
      exp_q.push_back(last_rec);
      wait_valid(40, lat);
      n_cmp++;
      if (lat !== 32) begin
        n_bad++;
        $display("FAIL random_latency[%0d]: got %0d want 32", i, lat);
      end
      idle($urandom_range(1, 5));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int v0, o0;
    v0 = valid_cnt;
    o0 = overrun_cnt;
    drive_frame(12'hA5C);
    exp_q.push_back(last_rec);
    drive_frame(12'h3F1);  // its end lands during DIV and is discarded
    wait_valid(40, lat);
    n_cmp++;
    if (lat !== 20) begin
      n_bad++;
      $display("FAIL b2b_latency: got %0d want 20", lat);
    end
    idle(40);
    n_cmp++;
    if (valid_cnt - v0 !== 1) begin
      n_bad++;
      $display("FAIL b2b_valid_count: got %0d want 1", valid_cnt - v0);
    end
    n_cmp++;
    if (overrun_cnt - o0 !== 1) begin
      n_bad++;
      $display("FAIL b2b_overrun_count: got %0d want 1", overrun_cnt - o0);
    end
  endtask

  task automatic test_reset_mid_divide();
    int lat;
    int v0;
    drive_frame(12'h0F0);  // result discarded by reset
    idle(10);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_valid, a_found, a_overrun, a_pixcount, a_cx, a_cy, a_minx, a_maxx, a_miny, a_maxy, a_state} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got cnt=%0d cent=(%0d,%0d) state=%0d, want all 0",
        a_pixcount, a_cx, a_cy, a_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    v0 = valid_cnt;
    idle(40);
    n_cmp++;
    if (valid_cnt !== v0) begin
      n_bad++;
      $display("FAIL midreset_no_valid: got %0d results want 0", valid_cnt - v0);
    end
    drive_frame(12'h942);
    exp_q.push_back(last_rec);
    wait_valid(40, lat);
    n_cmp++;
    if (lat !== 32) begin
      n_bad++;
      $display("FAIL midreset_next_latency: got %0d want 32", lat);
    end
    idle(3);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_hit();
    test_empty_frame();
    test_three_hits();
    test_ignored_samples();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_divide();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_results: got %0d unproduced results want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
